// File: rtl/ctpuf_resp_engine.sv
// ---------------------------------------------------------------------------
// ctpuf_resp_engine
//
// Challenge-feedback PUF response engine. Each response bit is produced by
// evaluating a STAGES-deep swap/invert delay chain VOTES times. An arbiter
// flop samples top_out ^ bottom_out after each launch. The votes are reduced
// by majority, and the winning bit is shifted into both the response word
// and the challenge register. Because the challenge is fed back this way,
// every later bit depends on the bits produced before it.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   start       request a new response word (sampled only when idle)
//   seed        initial challenge, captured together with start
//   busy        high whenever the engine is not idle
//   resp_valid  response word is available (held until resp_ready)
//   resp_ready  consumer accepts the word
//   resp        response word; the first bit generated ends in resp[0]
//   unstable    at least one bit of the word had a non-unanimous vote
// ---------------------------------------------------------------------------
module ctpuf_resp_engine #(
  parameter int STAGES    = 32,
  parameter int CHAL_W    = 48,
  parameter int VOTES     = 3,
  parameter int RESP_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    seed,
  output logic                 busy,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] resp,
  output logic                 unstable
);

  // Both counters are sized so that they can hold their terminal value
  // (VOTES, RESP_BITS) without wrapping.
  localparam int VW = $clog2(VOTES + 1);
  localparam int BW = $clog2(RESP_BITS + 1);

  localparam logic [VW-1:0] VOTES_V  = VW'(VOTES);
  localparam logic [VW-1:0] HALF_V   = VW'(VOTES / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LAUNCH,
    S_SAMPLE,
    S_DECIDE,
    S_HOLD
  } state_t;

  state_t                 state_reg, state_next;
  logic [CHAL_W-1:0]      chal_reg, chal_next;
  logic [RESP_BITS-1:0]   resp_reg, resp_next;
  logic                   unstable_reg, unstable_next;
  logic                   arb_reg;
  logic [VW-1:0]          ones_reg, ones_next;
  logic [VW-1:0]          vote_reg, vote_next;
  logic [BW-1:0]          bit_reg, bit_next;

  // -------------------------------------------------------------------------
  // Delay chain
  // -------------------------------------------------------------------------
  logic                   launch;
  logic [STAGES-1:0]      sel_c0;
  logic [STAGES-1:0]      sel_c1;
  logic                   chain_top;
  logic                   chain_bot;
  logic                   mid_top;
  logic                   mid_bot;
  logic                   raw;

  // Stage i consumes challenge bits 2i and 2i+1. The indices wrap modulo
  // CHAL_W, so a chain longer than CHAL_W/2 stages reuses challenge bits.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage_sel
      localparam int C0_IDX = (2 * gi) % CHAL_W;
      localparam int C1_IDX = (2 * gi + 1) % CHAL_W;
      assign sel_c0[gi] = chal_reg[C0_IDX];
      assign sel_c1[gi] = chal_reg[C1_IDX];
    end
  endgenerate

  // The chain is written as a loop inside one combinational process rather
  // than as a wire array. This keeps the ripple through the stages free of
  // self-referencing vector bits.
  always_comb begin
    chain_top = launch;
    chain_bot = launch;
    mid_top   = 1'b0;
    mid_bot   = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      mid_top   = sel_c0[i] ? chain_bot : chain_top;
      mid_bot   = sel_c0[i] ? chain_top : chain_bot;
      chain_top = mid_top;
      chain_bot = mid_bot ^ sel_c1[i];
    end
    raw = chain_top ^ chain_bot;
  end

  // -------------------------------------------------------------------------
  // Vote reduction and shift helpers
  // -------------------------------------------------------------------------
  logic                 bit_val;
  logic                 split_vote;
  logic [RESP_BITS-1:0] resp_shift;
  logic [CHAL_W-1:0]    chal_shift;

  always_comb begin
    bit_val    = (ones_reg > HALF_V);
    split_vote = (ones_reg != '0) && (ones_reg != VOTES_V);
    // Shifting right and then patching the MSB also works for a 1-bit word,
    // where a part-select such as [RESP_BITS-1:1] would be reversed.
    resp_shift                = resp_reg >> 1;
    resp_shift[RESP_BITS-1]   = bit_val;
    chal_shift                = chal_reg >> 1;
    chal_shift[CHAL_W-1]      = bit_val;
  end

  // -------------------------------------------------------------------------
  // Control FSM: next-state and datapath updates
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    chal_next     = chal_reg;
    resp_next     = resp_reg;
    unstable_next = unstable_reg;
    ones_next     = ones_reg;
    vote_next     = vote_reg;
    bit_next      = bit_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          chal_next     = seed;
          resp_next     = '0;
          unstable_next = 1'b0;
          ones_next     = '0;
          vote_next     = '0;
          bit_next      = '0;
          state_next    = S_PRE;
        end
      end

      // One quiet cycle with the launch held low, so the chain settles
      // before every evaluation.
      S_PRE: begin
        state_next = S_LAUNCH;
      end

      S_LAUNCH: begin
        state_next = S_SAMPLE;
      end

      S_SAMPLE: begin
        ones_next = ones_reg + VW'(arb_reg);
        vote_next = vote_reg + VW'(1);
        if ((vote_reg + VW'(1)) == VOTES_V) begin
          state_next = S_DECIDE;
        end else begin
          state_next = S_PRE;
        end
      end

      S_DECIDE: begin
        resp_next     = resp_shift;
        chal_next     = chal_shift;
        unstable_next = unstable_reg | split_vote;
        ones_next     = '0;
        vote_next     = '0;
        if (bit_reg == LAST_BIT) begin
          state_next = S_HOLD;
        end else begin
          bit_next   = bit_reg + BW'(1);
          state_next = S_PRE;
        end
      end

      // The word is frozen here. A start that arrives together with
      // resp_ready is dropped, because start is only looked at in IDLE.
      S_HOLD: begin
        if (resp_ready) begin
          bit_next   = '0;
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      chal_reg     <= '0;
      resp_reg     <= '0;
      unstable_reg <= 1'b0;
      arb_reg      <= 1'b0;
      ones_reg     <= '0;
      vote_reg     <= '0;
      bit_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      chal_reg     <= chal_next;
      resp_reg     <= resp_next;
      unstable_reg <= unstable_next;
      // The arbiter samples on every edge. Only the sample taken at the end
      // of LAUNCH is consumed, and that happens in SAMPLE.
      arb_reg      <= raw;
      ones_reg     <= ones_next;
      vote_reg     <= vote_next;
      bit_reg      <= bit_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign launch     = (state_reg == S_LAUNCH);
  assign busy       = (state_reg != S_IDLE);
  assign resp_valid = (state_reg == S_HOLD);
  assign resp       = resp_reg;
  assign unstable   = unstable_reg;

endmodule

// File: tb/tb_ctpuf_resp_engine.sv
// ---------------------------------------------------------------------------
// tb_ctpuf_resp_engine
//
// Directed test of ctpuf_resp_engine. The bench uses two instances:
//   dut_a : STAGES=4, CHAL_W=8, VOTES=3, RESP_BITS=4 (40 edges per word)
//   dut_b : STAGES=5, CHAL_W=8, VOTES=1, RESP_BITS=1 (4 edges per word,
//           with challenge-bit wrap in stage 4)
// In zero-delay simulation the raw arbiter value is the XOR of the c1 bits.
// The expected words below were worked out by hand from that rule.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ctpuf_resp_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;

  logic       start_a;
  logic [7:0] seed_a;
  logic       busy_a;
  logic       valid_a;
  logic       ready_a;
  logic [3:0] resp_a;
  logic       unst_a;

  logic       start_b;
  logic [7:0] seed_b;
  logic       busy_b;
  logic       valid_b;
  logic       ready_b;
  logic [0:0] resp_b;
  logic       unst_b;

  int checks   = 0;
  int failures = 0;

  ctpuf_resp_engine #(
    .STAGES(4), .CHAL_W(8), .VOTES(3), .RESP_BITS(4)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .seed(seed_a),
    .busy(busy_a), .resp_valid(valid_a), .resp_ready(ready_a),
    .resp(resp_a), .unstable(unst_a)
  );

  ctpuf_resp_engine #(
    .STAGES(5), .CHAL_W(8), .VOTES(1), .RESP_BITS(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .seed(seed_b),
    .busy(busy_b), .resp_valid(valid_b), .resp_ready(ready_b),
    .resp(resp_b), .unstable(unst_b)
  );

  // Starts one word on dut_a and checks its latency, word and unstable flag.
  // When poke is set, start (with a different seed) and resp_ready are both
  // pulsed while the engine is busy. Neither pulse may disturb the word.
  task automatic run_a(input logic [7:0] s, input logic [3:0] exp,
                       input string name, input bit poke);
    int n;
    @(negedge clk);
    seed_a  = s;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy: got %b want 1", name, busy_a);
    end
    n = 0;
    while (valid_a !== 1'b1 && n < 200) begin
      if (poke && n == 7) begin
        start_a = 1'b1;
        seed_a  = 8'hFF;
        ready_a = 1'b1;
      end else begin
        start_a = 1'b0;
        ready_a = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start_a = 1'b0;
    ready_a = 1'b0;
    $display("txn %s: seed=%h resp=%h unstable=%b edges=%0d", name, s, resp_a, unst_a, n);
    checks++;
    if (n != 40) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges want 40", name, n);
    end
    checks++;
    if (resp_a !== exp) begin
      failures++;
      $display("FAIL %s_resp: got %h want %h", name, resp_a, exp);
    end
    checks++;
    if (unst_a !== 1'b0) begin
      failures++;
      $display("FAIL %s_unstable: got %b want 0", name, unst_a);
    end
  endtask

  // Accepts the word that dut_a is holding and checks that it returns to idle.
  task automatic release_a(input string name);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: got busy=%b valid=%b want 0 0", name, busy_a, valid_a);
    end
  endtask

  task automatic run_b(input logic [7:0] s, input logic [0:0] exp, input string name);
    int n;
    @(negedge clk);
    seed_b  = s;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (valid_b !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    $display("txn %s: seed=%h resp=%b edges=%0d", name, s, resp_b, n);
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges want 4", name, n);
    end
    checks++;
    if (resp_b !== exp) begin
      failures++;
      $display("FAIL %s_resp: got %b want %b", name, resp_b, exp);
    end
    checks++;
    if (unst_b !== 1'b0) begin
      failures++;
      $display("FAIL %s_unstable: got %b want 0", name, unst_b);
    end
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    checks++;
    if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: got busy=%b valid=%b want 0 0", name, busy_b, valid_b);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    start_a = 1'b0; seed_a = 8'h00; ready_a = 1'b0;
    start_b = 1'b0; seed_b = 8'h00; ready_b = 1'b0;
    repeat (2) @(negedge clk);
    $display("txn reset: busy=%b valid=%b resp=%h unstable=%b", busy_a, valid_a, resp_a, unst_a);
    checks++;
    if ({busy_a, valid_a, resp_a, unst_a} !== 7'b0) begin
      failures++;
      $display("FAIL reset_a: got busy=%b valid=%b resp=%h unstable=%b want all 0",
               busy_a, valid_a, resp_a, unst_a);
    end
    checks++;
    if ({busy_b, valid_b, resp_b, unst_b} !== 4'b0) begin
      failures++;
      $display("FAIL reset_b: got busy=%b valid=%b resp=%b unstable=%b want all 0",
               busy_b, valid_b, resp_b, unst_b);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Every c1 bit is 0, so every bit evaluates to 0.
  task automatic test_seed_zero();
    run_a(8'h00, 4'h0, "seed00", 1'b0);
    release_a("seed00");
  endtask

  // Challenge FF->7F->BF->5F->2F gives bits 0,1,0,0, so resp=4'b0010.
  task automatic test_seed_ff();
    run_a(8'hFF, 4'b0010, "seedFF", 1'b0);
    release_a("seedFF");
  endtask

  // Challenge 02->81->C0->E0->70 gives bits 1,1,1,0, so resp=4'h7. The run
  // also pulses start and resp_ready while the engine is busy.
  task automatic test_seed_02_busy_start();
    run_a(8'h02, 4'h7, "seed02", 1'b1);
    release_a("seed02");
  endtask

  task automatic test_hold();
    run_a(8'h02, 4'h7, "hold", 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (valid_a !== 1'b1 || resp_a !== 4'h7) begin
        failures++;
        $display("FAIL hold_stable_%0d: got valid=%b resp=%h want 1 7", i, valid_a, resp_a);
      end
      start_a = (i == 3);
      seed_a  = 8'h00;
      @(negedge clk);
    end
    start_a = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL hold_after_start: got valid=%b busy=%b want 1 1", valid_a, busy_a);
    end
    // When start and ready arrive together, ready wins and start is dropped.
    start_a = 1'b1;
    ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    ready_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      failures++;
      $display("FAIL hold_exit: got busy=%b valid=%b want 0 0", busy_a, valid_a);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_queue: got busy=%b want 0", busy_a);
    end
    $display("txn hold: exit to idle busy=%b", busy_a);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    seed_a  = 8'h02;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    // 13 more edges puts the engine inside the vote loop of the 2nd bit.
    // By then the first bit (1) has already been shifted into resp[3].
    repeat (13) @(negedge clk);
    checks++;
    if (resp_a !== 4'h8 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL midrun_state: got resp=%h busy=%b want 8 1", resp_a, busy_a);
    end
    reset = 1'b0;
    #1;
    $display("txn reset_mid: busy=%b valid=%b resp=%h unstable=%b", busy_a, valid_a, resp_a, unst_a);
    checks++;
    if ({busy_a, valid_a, resp_a, unst_a} !== 7'b0) begin
      failures++;
      $display("FAIL reset_mid_async: got busy=%b valid=%b resp=%h unstable=%b want all 0",
               busy_a, valid_a, resp_a, unst_a);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_resume: got busy=%b want 0", busy_a);
    end
    run_a(8'h02, 4'h7, "after_reset", 1'b0);
    release_a("after_reset");
  endtask

  // Stage 4 wraps onto C[0]/C[1]. Seed 02 uses C[1] twice, so the parity
  // is 0. Seed 08 uses C[3] once, so the parity is 1.
  task automatic test_wrap();
    run_b(8'h02, 1'b0, "wrap02");
    run_b(8'h08, 1'b1, "wrap08");
  endtask

  initial begin
    test_reset();
    test_seed_zero();
    test_seed_ff();
    test_seed_02_busy_start();
    test_hold();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
